timer_n_bit_prescaled: RTL and testbench
========================================

# timer_n_bit_prescaled

Parametrised down-counting timer with programmable prescaler, compare-match output, pause/resume, restart-on-start and a sticky, maskable rollover interrupt. It is the general-purpose timer for the Counters_and_Timers library. It sits beside the counters as a peripheral driven by a controller issuing single-cycle commands, and exposes flags plus a level interrupt.

## Interface
- WIDTH, 8: timer count width, minimum 2.
- PRESCALE_WIDTH, 4: prescaler width; divide ratio is Prescale_Value_In + 1.
- Clk_In  input  1  sole clock; all logic on rising edge.
- Reset_In  input  1  synchronous, active-high reset; overrides every other input.
- Enable_In  input  1  clock enable; low freezes all state and ignores commands.
- Start_Timer_Command_In  input  1  single-cycle pulse: load and run, or restart.
- Stop_Timer_Command_In  input  1  single-cycle pulse: return to IDLE.
- Pause_In  input  1  level; high holds the count while started.
- Timer_Periodic_Oneshotb_Mode_In  input  1  1 = periodic reload, 0 = one-shot.
- Preload_Timer_Value_In  input  WIDTH  start/reload value.
- Compare_Value_In  input  WIDTH  match value.
- Prescale_Value_In  input  PRESCALE_WIDTH  prescaler terminal value.
- Irq_Enable_In  input  1  interrupt mask.
- Irq_Clear_In  input  1  single-cycle pulse: clears the pending rollover.
- Timer_Running_Flag_Out  output  1  state is RUNNING.
- Timer_Paused_Flag_Out  output  1  state is PAUSED.
- Timer_Rollover_Flag_Out  output  1  one-cycle pulse on expiry.
- Timer_Match_Flag_Out  output  1  one-cycle pulse on compare match.
- Timer_Irq_Out  output  1  Rollover_Pending AND Irq_Enable_In (combinational on the mask).
- Timer_Count_Out  output  WIDTH  current count.

## Operation
- States: IDLE, RUNNING, PAUSED. All outputs and internal registers are 0 at reset; the state is IDLE.
- Per-cycle priority when Enable_In = 1: Stop > Start > Pause > tick.
- Stop from any state: go to IDLE, count = 0, prescaler = 0. Pending interrupt is untouched.
- Start from any state: count = Preload, prescaler = 0, Prescale_Value_In latched internally, state = RUNNING. A Start while RUNNING or PAUSED is a restart.
- RUNNING with Pause_In = 1: go to PAUSED; count and prescaler hold.
- PAUSED with Pause_In = 0: return to RUNNING.
- Prescaler, RUNNING only:
  - Increments each cycle.
  - Tick occurs when it equals the latched value; it then wraps to 0.
  - Latched value 0 gives a tick every cycle.
- On a tick with count != 0: count decrements by 1.
- On a tick with count == 0 (expiry):
  - Rollover pulse is asserted and Rollover_Pending is set.
  - Periodic mode: count = live Preload_Timer_Value_In and the timer stays RUNNING.
  - One-shot mode: count = 0, state = IDLE.
- Match: pulse when a tick writes a new count equal to Compare_Value_In. This applies to both decrement and periodic reload. A load caused by Start never matches.
- Interrupt: Irq_Clear_In clears Rollover_Pending. If set and clear occur in the same cycle, set wins.
- Enable_In = 0: state, count, prescaler and pending are held. Rollover and match pulses are 0. Commands are ignored and not queued.
- Preload = 0 is legal: the timer expires on every tick.

## Timing
- All outputs are registered, except the mask gate in Timer_Irq_Out.
- Command latency is 1 cycle: after the Start edge, Timer_Count_Out = Preload and Timer_Running_Flag_Out = 1.
- With Start sampled at edge 0:
  - The first decrement is at edge P+1, where P is the latched prescale.
  - Expiry is at edge (Preload+1)·(P+1).
  - The periodic period is (Preload+1)·(P+1) cycles.
- Rollover and match pulses are high for exactly one cycle, coincident with the new count value.
- Pause entered at edge k and released at edge k+n delays all subsequent ticks by exactly n cycles.
- Reset asserted mid-count returns all outputs to 0 on that edge.

## Test plan
- Reset, then Start with Preload = 5, P = 0, periodic -> count 5,4,3,2,1,0,5…; rollover pulse on every reload, period 6 cycles; Running = 1 throughout.
- One-shot, Preload = 3, P = 2 -> each count value is held 3 cycles; expiry 12 cycles after Start; then Running = 0 and count = 0.
- Preload = 15, Compare = 7, P = 0, Irq_Enable = 1 -> match pulse when count becomes 7; Irq_Out rises at rollover and stays high until Irq_Clear; clear and set in the same cycle keep it high.
- Pause for 4 cycles at count 9 (Preload = 12) -> Paused = 1 and count holds 9; after release, expiry is 4 cycles later than without the pause.
- Restart and Stop: Start at count 2 reloads Preload and zeroes the prescaler; simultaneous Start and Stop -> IDLE, count 0.
- Enable_In low for 3 cycles mid-count -> count frozen, no pulses, a Start issued in that window ignored; Reset_In asserted mid-run -> all outputs 0 on the next edge.

Source files
------------

// File: rtl/timer_n_bit_prescaled.sv
// Down-counting timer with programmable prescaler, compare match, pause/resume
// and a sticky, maskable rollover interrupt.
module timer_n_bit_prescaled #(
  parameter int unsigned WIDTH          = 8,
  parameter int unsigned PRESCALE_WIDTH = 4
) (
  input  logic                      Clk_In,
  input  logic                      Reset_In,
  input  logic                      Enable_In,
  input  logic                      Start_Timer_Command_In,
  input  logic                      Stop_Timer_Command_In,
  input  logic                      Pause_In,
  input  logic                      Timer_Periodic_Oneshotb_Mode_In,
  input  logic [WIDTH-1:0]          Preload_Timer_Value_In,
  input  logic [WIDTH-1:0]          Compare_Value_In,
  input  logic [PRESCALE_WIDTH-1:0] Prescale_Value_In,
  input  logic                      Irq_Enable_In,
  input  logic                      Irq_Clear_In,
  output logic                      Timer_Running_Flag_Out,
  output logic                      Timer_Paused_Flag_Out,
  output logic                      Timer_Rollover_Flag_Out,
  output logic                      Timer_Match_Flag_Out,
  output logic                      Timer_Irq_Out,
  output logic [WIDTH-1:0]          Timer_Count_Out
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUNNING = 2'd1,
    ST_PAUSED  = 2'd2
  } state_e;

  state_e                    state_q, state_d;
  logic [WIDTH-1:0]          count_q, count_d;
  logic [PRESCALE_WIDTH-1:0] presc_q, presc_d;
  logic [PRESCALE_WIDTH-1:0] presc_lat_q, presc_lat_d;
  logic                      pending_q, pending_d;
  logic                      rollover_q, rollover_d;
  logic                      match_q, match_d;
  logic                      running_q, running_d;
  logic                      paused_q, paused_d;

  // Next-state: Stop > Start > Pause > prescaler tick. A resume cycle also
  // advances the prescaler, so a pause of n cycles delays ticks by exactly n.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    presc_d     = presc_q;
    presc_lat_d = presc_lat_q;
    pending_d   = pending_q;
    rollover_d  = 1'b0;
    match_d     = 1'b0;

    if (Enable_In) begin
      if (Irq_Clear_In) pending_d = 1'b0;

      if (Stop_Timer_Command_In) begin
        state_d = ST_IDLE;
        count_d = '0;
        presc_d = '0;
      end else if (Start_Timer_Command_In) begin
        state_d     = ST_RUNNING;
        count_d     = Preload_Timer_Value_In;
        presc_d     = '0;
        presc_lat_d = Prescale_Value_In;
      end else if (state_q != ST_IDLE) begin
        if (Pause_In) begin
          state_d = ST_PAUSED;
        end else begin
          state_d = ST_RUNNING;
          if (presc_q == presc_lat_q) begin
            presc_d = '0;
            if (count_q != '0) begin
              count_d = count_q - WIDTH'(1);
              match_d = (count_d == Compare_Value_In);
            end else begin
              rollover_d = 1'b1;
              pending_d  = 1'b1;
              if (Timer_Periodic_Oneshotb_Mode_In) begin
                count_d = Preload_Timer_Value_In;
                match_d = (Preload_Timer_Value_In == Compare_Value_In);
              end else begin
                count_d = '0;
                state_d = ST_IDLE;
              end
            end
          end else begin
            presc_d = presc_q + PRESCALE_WIDTH'(1);
          end
        end
      end
    end

    running_d = (state_d == ST_RUNNING);
    paused_d  = (state_d == ST_PAUSED);
  end

  always_ff @(posedge Clk_In) begin
    if (Reset_In) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      presc_q     <= '0;
      presc_lat_q <= '0;
      pending_q   <= 1'b0;
      rollover_q  <= 1'b0;
      match_q     <= 1'b0;
      running_q   <= 1'b0;
      paused_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      presc_q     <= presc_d;
      presc_lat_q <= presc_lat_d;
      pending_q   <= pending_d;
      rollover_q  <= rollover_d;
      match_q     <= match_d;
      running_q   <= running_d;
      paused_q    <= paused_d;
    end
  end

  assign Timer_Running_Flag_Out  = running_q;
  assign Timer_Paused_Flag_Out   = paused_q;
  assign Timer_Rollover_Flag_Out = rollover_q;
  assign Timer_Match_Flag_Out    = match_q;
  assign Timer_Count_Out         = count_q;
  // Mask is applied live so software can gate the line without a cycle delay.
  assign Timer_Irq_Out           = pending_q & Irq_Enable_In;

endmodule

// File: tb/tb_timer_n_bit_prescaled.sv
// Scoreboard bench for timer_n_bit_prescaled: driver + reference model push
// expected outputs each edge; an independent monitor pops and compares.
module tb_timer_n_bit_prescaled;

  localparam int unsigned W  = 8;
  localparam int unsigned PW = 4;
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_PAU  = 2;

  logic          clk = 1'b0;
  logic          rst, en, start, stop, pause, periodic, irq_en, clr;
  logic [W-1:0]  pre, cmp;
  logic [PW-1:0] presc;

  logic          running, paused, rollover, match, irq;
  logic [W-1:0]  count;

  typedef struct {
    logic [W-1:0] count;
    bit running;
    bit paused;
    bit rollover;
    bit match;
    bit pending;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Reference model: a per-tick countdown of remaining active cycles.
  int           m_st;
  logic [W-1:0] m_cnt;
  int           m_wait;
  int           m_p;
  bit           m_pend, m_ro, m_mt;

  timer_n_bit_prescaled #(.WIDTH(W), .PRESCALE_WIDTH(PW)) dut (
    .Clk_In                          (clk),
    .Reset_In                        (rst),
    .Enable_In                       (en),
    .Start_Timer_Command_In          (start),
    .Stop_Timer_Command_In           (stop),
    .Pause_In                        (pause),
    .Timer_Periodic_Oneshotb_Mode_In (periodic),
    .Preload_Timer_Value_In          (pre),
    .Compare_Value_In                (cmp),
    .Prescale_Value_In               (presc),
    .Irq_Enable_In                   (irq_en),
    .Irq_Clear_In                    (clr),
    .Timer_Running_Flag_Out          (running),
    .Timer_Paused_Flag_Out           (paused),
    .Timer_Rollover_Flag_Out         (rollover),
    .Timer_Match_Flag_Out            (match),
    .Timer_Irq_Out                   (irq),
    .Timer_Count_Out                 (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  task automatic model_step();
    m_ro = 1'b0;
    m_mt = 1'b0;
    if (rst) begin
      m_st = M_IDLE; m_cnt = '0; m_wait = 0; m_p = 0; m_pend = 1'b0;
    end else if (en) begin
      if (clr) m_pend = 1'b0;
      if (stop) begin
        m_st = M_IDLE; m_cnt = '0;
      end else if (start) begin
        m_st = M_RUN; m_cnt = pre; m_p = int'(presc); m_wait = m_p + 1;
      end else if (m_st != M_IDLE && pause) begin
        m_st = M_PAU;
      end else if (m_st != M_IDLE) begin
        m_st = M_RUN;
        m_wait--;
        if (m_wait == 0) begin
          m_wait = m_p + 1;
          if (m_cnt != 0) begin
            m_cnt = m_cnt - 1'b1;
            m_mt  = (m_cnt == cmp);
          end else begin
            m_ro = 1'b1;
            m_pend = 1'b1;
            if (periodic) begin
              m_cnt = pre;
              m_mt  = (pre == cmp);
            end else begin
              m_cnt = '0;
              m_st  = M_IDLE;
            end
          end
        end
      end
    end
  endtask

  // One clock edge: model consumes the inputs that were stable across it.
  task automatic step();
    exp_t e;
    @(posedge clk);
    model_step();
    e.count = m_cnt; e.running = (m_st == M_RUN); e.paused = (m_st == M_PAU);
    e.rollover = m_ro; e.match = m_mt; e.pending = m_pend;
    exp_q.push_back(e);
    #1;
    start = 1'b0; stop = 1'b0; clr = 1'b0;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("count",    32'(count),    32'(e.count));
      chk("running",  32'(running),  32'(e.running));
      chk("paused",   32'(paused),   32'(e.paused));
      chk("rollover", 32'(rollover), 32'(e.rollover));
      chk("match",    32'(match),    32'(e.match));
      chk("irq",      32'(irq),      32'(e.pending & irq_en));
    end
  end

  initial begin
    rst = 1'b1; en = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0;
    periodic = 1'b1; irq_en = 1'b0; clr = 1'b0;
    pre = '0; cmp = 8'hFF; presc = '0;
    m_st = M_IDLE; m_cnt = '0; m_wait = 0; m_p = 0; m_pend = 1'b0;
    #1;
    steps(2);
    rst = 1'b0;
    steps(1);

    // Periodic, Preload 5, P 0
    pre = 8'd5; presc = 4'd0; periodic = 1'b1; start = 1'b1;
    steps(15);

    // One-shot, Preload 3, P 2
    stop = 1'b1; steps(1);
    pre = 8'd3; presc = 4'd2; periodic = 1'b0; start = 1'b1;
    steps(16);

    // Match at 7 and sticky interrupt
    pre = 8'd15; cmp = 8'd7; presc = 4'd0; periodic = 1'b1; irq_en = 1'b1;
    start = 1'b1;
    steps(20);
    clr = 1'b1; steps(3);
    irq_en = 1'b0; steps(1); irq_en = 1'b1;
    pre = 8'd0; start = 1'b1; steps(1);
    for (int i = 0; i < 3; i++) begin clr = 1'b1; step(); end

    // Pause four cycles at count 9
    stop = 1'b1; clr = 1'b1; steps(1);
    pre = 8'd12; cmp = 8'd0; presc = 4'd0; periodic = 1'b0; start = 1'b1;
    steps(4);
    pause = 1'b1; steps(4);
    pause = 1'b0; steps(14);

    // Restart mid-count, then Start and Stop together
    pre = 8'd10; presc = 4'd1; periodic = 1'b1; start = 1'b1;
    steps(17);
    start = 1'b1; steps(4);
    start = 1'b1; stop = 1'b1; steps(3);

    // Enable low with an ignored Start, then reset mid-run
    pre = 8'd10; presc = 4'd0; start = 1'b1; steps(3);
    en = 1'b0; steps(1); start = 1'b1; pre = 8'd50; steps(2);
    en = 1'b1; steps(3);
    rst = 1'b1; steps(1);
    rst = 1'b0; steps(2);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst   = ($urandom_range(0, 399) == 0);
      en    = ($urandom_range(0, 9) != 0);
      start = ($urandom_range(0, 39) == 0);
      stop  = ($urandom_range(0, 119) == 0);
      clr   = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 14) == 0) pause = ~pause;
      if ($urandom_range(0, 29) == 0) irq_en = ~irq_en;
      if ($urandom_range(0, 59) == 0) periodic = ~periodic;
      if ($urandom_range(0, 49) == 0)
        pre = ($urandom_range(0, 3) == 0) ? W'($urandom) : W'($urandom_range(0, 12));
      if ($urandom_range(0, 49) == 0) cmp = W'($urandom_range(0, 12));
      if ($urandom_range(0, 29) == 0)
        presc = ($urandom_range(0, 4) == 0) ? PW'($urandom) : PW'($urandom_range(0, 3));
      step();
    end

    @(negedge clk);
    @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
